csa_resolve_seq: RTL and testbench

//  Sequential carry-propagate resolver: consumes one carry-save pair (pv_s, pv_c) from a CSA tree
//  and produces the binary sum pv_s + pv_c, resolving CHUNK bits per clock with a rippled carry.

---
 rtl/csa_resolve_seq.sv | 140 ++++++++++++++
 tb/tb_csa_resolve_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_seq.sv
// Sequential carry-propagate resolver: turns one carry-save pair into a binary sum,
// CHUNK bits per clock with the carry rippled between cycles, behind valid/ready handshakes.
module csa_resolve_seq #(
    parameter int MAX   = 7,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [MAX-1:0] pv_s,
    input  logic [MAX-1:0] pv_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MAX:0]   sum
);

    localparam int NSEG = (MAX + CHUNK - 1) / CHUNK;
    localparam int PW   = NSEG * CHUNK;
    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEGW-1:0] LAST_SEG = SEGW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [PW-1:0]   s_r;
    logic [PW-1:0]   c_r;
    logic [MAX:0]    acc_r;
    logic [MAX:0]    acc_nx_s;
    logic [SEGW-1:0] seg_r;
    logic            carry_r;
    logic            out_valid_r;
    logic            in_ready_s;
    logic            accept_s;
    logic            last_seg_s;
    int              base_s;
    logic [CHUNK-1:0] s_seg_s;
    logic [CHUNK-1:0] c_seg_s;
    logic [CHUNK:0]   add_s;

    // Operands are zero-padded to whole chunks, so the last partial segment needs no masking.
    assign base_s     = int'(seg_r) * CHUNK;
    assign s_seg_s    = s_r[base_s +: CHUNK];
    assign c_seg_s    = c_r[base_s +: CHUNK];
    assign add_s      = {1'b0, s_seg_s} + {1'b0, c_seg_s} + {{CHUNK{1'b0}}, carry_r};
    assign last_seg_s = (seg_r == LAST_SEG);
    assign accept_s   = in_valid && in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign sum       = acc_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nx_s = ADD;
                else          state_nx_s = IDLE;
            end
            ADD: begin
                if (last_seg_s) state_nx_s = DONE;
                else            state_nx_s = ADD;
            end
            DONE: begin
                if (out_ready && in_valid) state_nx_s = ADD;
                else if (out_ready)        state_nx_s = IDLE;
                else                       state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Input-side ready decode; DONE passes downstream readiness through for back-to-back pairs
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            ADD:     in_ready_s = 1'b0;
            DONE:    in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Merge the current segment (plus its carry-out into the next bit) into the result
    always_comb begin
        acc_nx_s = acc_r;
        for (int i = 0; i <= MAX; i++) begin
            if ((i >= base_s) && (i <= base_s + CHUNK)) begin
                acc_nx_s[i] = add_s[i - base_s];
            end else begin
                acc_nx_s[i] = acc_r[i];
            end
        end
    end

    // Datapath: operand capture on accept, one segment resolved per ADD cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r     <= {PW{1'b0}};
            c_r     <= {PW{1'b0}};
            acc_r   <= {(MAX + 1){1'b0}};
            seg_r   <= {SEGW{1'b0}};
            carry_r <= 1'b0;
        end else if (accept_s) begin
            s_r     <= PW'(pv_s);
            c_r     <= PW'(pv_c);
            seg_r   <= {SEGW{1'b0}};
            carry_r <= 1'b0;
        end else if (state_r == ADD) begin
            acc_r   <= acc_nx_s;
            carry_r <= add_s[CHUNK];
            seg_r   <= last_seg_s ? {SEGW{1'b0}} : (seg_r + SEGW'(1));
        end
    end

    // Registered output-valid, tracking entry into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nx_s == DONE);
        end
    end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Bench for csa_resolve_seq: directed table and corner sequences on a CHUNK=4 instance,
// plus random scoreboarded traffic on CHUNK = 1, 3, 7, 8 instances.
module tb_csa_resolve_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] pv_s;
    logic [6:0] pv_c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;

    int n_vec = 0;
    int n_err = 0;
    int gdone_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [6:0] s;
        logic [6:0] c;
        logic [7:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    csa_resolve_seq #(.MAX(7), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pv_s      (pv_s),
        .pv_c      (pv_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one pair on the main instance and push its expected sum when accepted
    task automatic send(input logic [6:0] s, input logic [6:0] c, input logic [7:0] exp);
        int t;
        @(negedge clk);
        pv_s = s; pv_c = c; in_valid = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        else           exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        pv_s = 7'($urandom); pv_c = 7'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(negedge clk); t++;
        end
        if (t >= 100) check(name, out_valid, 0);
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk); t++;
        end
        if (!out_valid) check(name, out_valid, 1);
    endtask

    // Count edges from the accepting edge until out_valid; called on the negedge after accept
    task automatic latency(input string name, input int need);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        check(name, cnt, need);
    endtask

    // Main scoreboard: compares on every output handshake
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("main_spurious_output", exp_q.size(), 1);
            else                   check("main_sum", sum, exp_q.pop_front());
        end
    end

    for (genvar g = 0; g < 4; g++) begin : rnd
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 7 : 8;
        localparam int NS = (7 + CH - 1) / CH;
        logic       iv;
        logic       ir;
        logic       ov;
        logic       orr;
        logic       rand_or = 1'b0;
        logic [6:0] s;
        logic [6:0] c;
        logic [7:0] sm;
        logic [7:0] q[$];

        csa_resolve_seq #(.MAX(7), .CHUNK(CH)) u (
            .clk       (clk),
            .rst_n     (rst2_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .pv_s      (s),
            .pv_c      (c),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (sm)
        );

        always @(negedge clk) orr = rand_or ? ($urandom_range(0, 3) != 0) : 1'b1;

        always @(negedge clk) begin
            #2;
            if (rst2_n && ov && orr) begin
                if (q.size() == 0) check($sformatf("rand_ch%0d_spurious", CH), q.size(), 1);
                else               check($sformatf("rand_ch%0d_sum", CH), sm, q.pop_front());
            end
        end

        initial begin
            int t;
            int cnt;
            iv = 1'b0; s = 7'h00; c = 7'h00;
            while (!rst2_n) @(negedge clk);
            // Latency probe: 7'h40 + 7'h40 with out_ready held high
            @(negedge clk);
            s = 7'h40; c = 7'h40; iv = 1'b1;
            #1;
            check($sformatf("ch%0d_probe_ready", CH), ir, 1);
            q.push_back(8'h80);
            @(negedge clk);
            iv = 1'b0;
            cnt = 0;
            while (!ov && cnt < 20) begin
                @(negedge clk); cnt++;
            end
            check($sformatf("ch%0d_latency", CH), cnt, NS);
            rand_or = 1'b1;
            for (int k = 0; k < 2500; k++) begin
                @(negedge clk);
                s = 7'($urandom); c = 7'($urandom); iv = 1'b1;
                #1;
                t = 0;
                while (!ir && t < 100) begin
                    @(negedge clk); #1; t++;
                end
                if (!ir) check($sformatf("ch%0d_accept_timeout", CH), ir, 1);
                else     q.push_back({1'b0, s} + {1'b0, c});
            end
            @(negedge clk);
            iv = 1'b0;
            t = 0;
            while ((q.size() != 0 || ov) && t < 200) begin
                @(negedge clk); t++;
            end
            check($sformatf("ch%0d_drain", CH), q.size(), 0);
            gdone_cnt++;
        end
    end

    initial begin
        vec_t vecs[6];
        int t;
        vecs[0] = '{s: 7'h7F, c: 7'h01, exp: 8'h80};
        vecs[1] = '{s: 7'h55, c: 7'h2A, exp: 8'h7F};
        vecs[2] = '{s: 7'h7F, c: 7'h7F, exp: 8'hFE};
        vecs[3] = '{s: 7'h00, c: 7'h00, exp: 8'h00};
        vecs[4] = '{s: 7'h40, c: 7'h40, exp: 8'h80};
        vecs[5] = '{s: 7'h01, c: 7'h7E, exp: 8'h7F};

        rst_n = 1'b0; rst2_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pv_s = 7'h00; pv_c = 7'h00;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].s, vecs[i].c, vecs[i].exp);
            wait_drain("table_drain");
        end

        // Latency: out_valid two edges after accept
        send(7'h7F, 7'h01, 8'h80);
        latency("latency_main", 2);
        wait_drain("latency_drain");

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        send(7'h7F, 7'h01, 8'h80);
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum_held", sum, 8'h80);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);

        // Back-to-back: second pair accepted on the handshake edge
        out_ready = 1'b0;
        send(7'h55, 7'h2A, 8'h7F);
        wait_valid("b2b_valid_timeout");
        @(negedge clk);
        out_ready = 1'b1; pv_s = 7'h10; pv_c = 7'h20; in_valid = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        exp_q.push_back(8'h30);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_no_valid_in_add", out_valid, 0);
        latency("b2b_latency", 2);
        wait_drain("b2b_drain");

        // Asynchronous reset in the middle of ADD
        send(7'h7F, 7'h7F, 8'hFE);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_out_valid", out_valid, 0);
            check("postrst_in_ready", in_ready, 1);
        end
        send(7'h01, 7'h01, 8'h02);
        wait_drain("postrst_drain");

        t = 0;
        while (gdone_cnt < 4 && t < 60000) begin
            @(negedge clk); t++;
        end
        check("random_instances_done", gdone_cnt, 4);
        check("main_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
